// File: rtl/ffmath_pkg.sv
// Shared GF(2^12) constants and the divider FSM state type for the EXU finite-field units.
// Field polynomial is x^12 + x^3 + 1; only its reduction tail is stored.
package ffmath_pkg;

    localparam int          GF12_W    = 12;
    localparam logic [11:0] GF12_POLY = 12'h009;
    localparam int          GF12_ITER = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/gf12_mul.sv
// Combinational GF(2^12) multiplier: carry-less 12x12 product reduced by x^12 + x^3 + 1.
// Latency: none (pure combinational). Backpressure: not applicable.
module gf12_mul
    import ffmath_pkg::*;
(
    input  logic [GF12_W-1:0] in_a,
    input  logic [GF12_W-1:0] in_b,
    output logic [GF12_W-1:0] out
);

    logic [2*GF12_W-2:0] w_prod;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < GF12_W; i++) begin
            if (in_b[i]) begin
                w_prod = w_prod ^ ({{(GF12_W-1){1'b0}}, in_a} << i);
            end
        end
        // Fold from the top bit down so a fold never re-sets an already cleared bit.
        for (int i = 2*GF12_W-2; i >= GF12_W; i--) begin
            if (w_prod[i]) begin
                w_prod = w_prod ^ ({{(GF12_W-2){1'b0}}, 1'b1, GF12_POLY} << (i - GF12_W));
            end
        end
    end

    assign out = w_prod[GF12_W-1:0];

endmodule

// File: rtl/ffdiv12_seq.sv
// GF(2^12) divider q = a * b^(2^12-2) by square-and-multiply, one step per clock.
// Latency: 11 cycles accept->out_valid (FFDIV12_FAST_ZERO_EN: zero operands go straight to DONE).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (II >= 13 cycles).
module ffdiv12_seq
    import ffmath_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int POLY_GRADE = 12
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_dz
);

    localparam logic [3:0] CNT_LAST = 4'(POLY_GRADE - 2);

    div_state_e        r_state;
    div_state_e        w_state_n;
    logic [GF12_W-1:0] r_sq;
    logic [GF12_W-1:0] r_acc;
    logic [3:0]        r_cnt;
    logic              r_dz;

    logic [GF12_W-1:0] w_sq_n;
    logic [GF12_W-1:0] w_acc_n;
    logic [GF12_W-1:0] w_a;
    logic [GF12_W-1:0] w_b;
    logic              w_b_zero;
    logic              w_unused_hi;

    assign w_a         = in_a[GF12_W-1:0];
    assign w_b         = in_b[GF12_W-1:0];
    assign w_b_zero    = (w_b == '0);
    assign w_unused_hi = ^{in_a[DATA_WIDTH-1:GF12_W], in_b[DATA_WIDTH-1:GF12_W]};

`ifdef FFDIV12_FAST_ZERO_EN
    logic w_zero_op;
    assign w_zero_op = (w_a == '0) | w_b_zero;
`endif

    gf12_mul u_square (
        .in_a (r_sq),
        .in_b (r_sq),
        .out  (w_sq_n)
    );

    gf12_mul u_accum (
        .in_a (r_acc),
        .in_b (w_sq_n),
        .out  (w_acc_n)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef FFDIV12_FAST_ZERO_EN
                    w_state_n = w_zero_op ? DONE : RUN;
`else
                    w_state_n = RUN;
`endif
                end
            end
            RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sq  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sq  <= w_b;
`ifdef FFDIV12_FAST_ZERO_EN
                        r_acc <= w_zero_op ? '0 : w_a;
`else
                        r_acc <= w_a;
`endif
                        r_cnt <= '0;
                        r_dz  <= w_b_zero;
                    end
                end
                RUN: begin
                    r_sq  <= w_sq_n;
                    r_acc <= w_acc_n;
                    r_cnt <= r_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = (r_state == DONE) ? {{(DATA_WIDTH-GF12_W){1'b0}}, r_acc} : '0;
    assign out_dz    = (r_state == DONE) & r_dz;

endmodule
